// File: rtl/adc_capture_scheduler_if.sv
// Bundle of the scheduler's command, ADC-driver and host-stream signals.
// The master modport is the scheduler itself; slave is the surrounding logic.
interface adc_capture_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
);
  logic                 start;
  logic [N_CH-1:0]      ch_enable;
  logic [N_CH-1:0]      adc_end;
  logic [N_CH-1:0]      adc_empty;
  logic [8*N_CH-1:0]    adc_q;
  logic [N_CH-1:0]      adc_bg;
  logic [N_CH-1:0]      adc_rdreq;
  logic [7:0]           out_data;
  logic [CH_W-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  modport master (
    input  start, ch_enable, adc_end, adc_empty, adc_q, out_ready,
    output adc_bg, adc_rdreq, out_data, out_ch, out_valid, busy, done, timeout_err
  );

  modport slave (
    output start, ch_enable, adc_end, adc_empty, adc_q, out_ready,
    input  adc_bg, adc_rdreq, out_data, out_ch, out_valid, busy, done, timeout_err
  );
endinterface

// File: rtl/adc_capture_scheduler.sv
// Runs one capture round: pulse begin on enabled channels, wait for their end
// flags, then drain each enabled FIFO in channel order onto an 8-bit stream.
module adc_capture_scheduler #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int WORDS   = 4096,
  parameter int TIMEOUT = 1000000
) (
  input logic                      clk,
  input logic                      rst,
  adc_capture_scheduler_if.master  bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ARM      = 3'd1;
  localparam logic [2:0] WAIT_END = 3'd2;
  localparam logic [2:0] SELECT   = 3'd3;
  localparam logic [2:0] READ     = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [12:0]     WORDS_C = 13'(WORDS);
  localparam logic [23:0]     TLIM    = 24'(TIMEOUT - 1);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  logic [2:0]      state;
  logic [N_CH-1:0] mask;
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] first_ch;
  logic [12:0]     word_cnt;
  logic [23:0]     tcnt;
  logic            pending;
  logic [N_CH-1:0] bg;
  logic [7:0]      data;
  logic [CH_W-1:0] data_ch;
  logic            valid;
  logic            terr;
  logic [N_CH-1:0] rdreq;
  logic            empty_sel;
  logic            issue;
  logic            finish;
  logic            all_end;

  assign empty_sel = bus.adc_empty[ch];
  assign all_end   = (bus.adc_end & mask) == mask;
  // A new read only goes out when the output register is free and nothing is in flight.
  assign issue     = (state == READ) && !pending && !valid && !empty_sel && (word_cnt < WORDS_C);
  assign finish    = (state == READ) && !pending && !valid && ((word_cnt == WORDS_C) || empty_sel);

  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (mask[i]) first_ch = CH_W'(i);
  end

  always_comb begin
    rdreq = '0;
    if (issue) rdreq[ch] = 1'b1;
  end

  assign bus.adc_bg      = bg;
  assign bus.adc_rdreq   = rdreq;
  assign bus.out_data    = data;
  assign bus.out_ch      = data_ch;
  assign bus.out_valid   = valid;
  assign bus.busy        = (state != IDLE) && (state != DONE);
  assign bus.done        = (state == DONE);
  assign bus.timeout_err = terr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mask     <= '0;
      ch       <= '0;
      word_cnt <= '0;
      tcnt     <= '0;
      pending  <= 1'b0;
      bg       <= '0;
      data     <= '0;
      data_ch  <= '0;
      valid    <= 1'b0;
      terr     <= 1'b0;
    end else begin
      bg <= '0;
      if (valid && bus.out_ready) valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          mask  <= bus.ch_enable;
          terr  <= 1'b0;
          state <= (bus.ch_enable == '0) ? DONE : ARM;
        end
        ARM: begin
          bg    <= mask;
          tcnt  <= '0;
          state <= WAIT_END;
        end
        WAIT_END: begin
          if (all_end) begin
            ch    <= first_ch;
            state <= SELECT;
          end else if (tcnt == TLIM) begin
            terr  <= 1'b1;
            state <= DONE;
          end else if (tcnt != '1) begin
            tcnt <= tcnt + 24'd1;
          end
        end
        SELECT: begin
          if (mask[ch]) begin
            word_cnt <= '0;
            state    <= READ;
          end else if (ch == LAST_CH) begin
            state <= DONE;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        READ: begin
          if (issue) pending <= 1'b1;
          // FIFO data lands one cycle after the read request.
          if (pending) begin
            data     <= bus.adc_q[8*ch +: 8];
            data_ch  <= ch;
            valid    <= 1'b1;
            pending  <= 1'b0;
            word_cnt <= word_cnt + 13'd1;
          end
          if (finish) begin
            if (ch == LAST_CH) state <= DONE;
            else begin
              ch    <= ch + CH_W'(1);
              state <= SELECT;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Scoreboard bench: directed rounds push expected stream words, a negedge
// monitor pops and compares them and gathers per-round pulse/read statistics.
module tb_adc_capture_scheduler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_capture_scheduler_if #(.N_CH(4), .CH_W(2)) bus();

  adc_capture_scheduler #(.N_CH(4), .CH_W(2), .WORDS(8), .TIMEOUT(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct packed { logic [1:0] c; logic [7:0] d; } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // ADC driver model: 1-cycle-latency FIFOs and an end flag 20 cycles after begin.
  logic [7:0] fifo [4][$];
  logic [3:0] stuck;
  logic [3:0] end_lvl = '0;
  int         end_timer = -1;

  always @(posedge clk) begin
    logic [31:0] qv;
    logic [3:0]  ev;
    qv = bus.adc_q;
    for (int i = 0; i < 4; i++)
      if (bus.adc_rdreq[i] && fifo[i].size() > 0) qv[8*i +: 8] = fifo[i].pop_front();
    for (int i = 0; i < 4; i++) ev[i] = (fifo[i].size() == 0);
    if (bus.start && !bus.busy) begin
      end_timer = -1;
      end_lvl   = '0;
    end else if (|bus.adc_bg) begin
      end_timer = 0;
      end_lvl   = '0;
    end else if (end_timer >= 0) begin
      end_timer++;
      if (end_timer >= 20) end_lvl = ~stuck;
    end
    bus.adc_q     <= qv;
    bus.adc_empty <= ev;
    bus.adc_end   <= end_lvl;
  end

  // Monitor
  logic [3:0] cur_mask;
  int   cyc_n = 0;
  int   bg_cycles, bg_at, done_at, done_cnt;
  logic [3:0] bg_val;
  logic terr_at_done;
  int   rd_cnt [4];
  int   words  [4];
  logic prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic [1:0] prev_ch;

  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (rst) prev_stall = 1'b0;
    else begin
      if (|bus.adc_bg) begin
        bg_cycles++;
        bg_val = bus.adc_bg;
        bg_at  = cyc_n;
      end
      if (|bus.adc_rdreq) begin
        for (int i = 0; i < 4; i++) if (bus.adc_rdreq[i]) rd_cnt[i]++;
        check("rdreq_while_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rdreq_outside_mask", {28'b0, bus.adc_rdreq & ~cur_mask}, 32'd0);
      end
      if (prev_stall) begin
        check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
        check("hold_data", {22'b0, bus.out_ch, bus.out_data}, {22'b0, prev_ch, prev_data});
      end
      if (bus.out_valid && bus.out_ready) begin
        words[bus.out_ch]++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stream_extra: got ch %0d data %0h, required no word", bus.out_ch, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_word", {22'b0, bus.out_ch, bus.out_data}, {22'b0, e.c, e.d});
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_ch    = bus.out_ch;
      if (bus.done) begin
        done_cnt++;
        done_at      = cyc_n;
        terr_at_done = bus.timeout_err;
        check("busy_at_done", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    bg_cycles = 0; bg_val = '0; bg_at = 0; done_at = 0; done_cnt = 0; terr_at_done = 1'b0;
    for (int i = 0; i < 4; i++) begin rd_cnt[i] = 0; words[i] = 0; end
  endtask

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) fifo[c].push_back(8'(8'h10 + c * 8'h10 + k));
  endtask

  task automatic flush_fifos();
    for (int i = 0; i < 4; i++) fifo[i].delete();
  endtask

  task automatic expect_round(input logic [3:0] m, input int n0, input int n1, input int n2, input int n3);
    int n [4];
    exp_t e;
    n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int k = 0; k < n[c] && k < 8; k++) begin
          e.c = 2'(c);
          e.d = 8'(8'h10 + c * 8'h10 + k);
          exp_q.push_back(e);
        end
  endtask

  task automatic start_round(input logic [3:0] m);
    clear_stats();
    cur_mask = m;
    bus.ch_enable = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_ignored_start(input logic [3:0] m);
    bus.ch_enable = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic finish_round(input int bound);
    for (int c = 0; c < bound && done_cnt == 0; c++) tick();
    if (done_cnt == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL round_done: got no done within %0d cycles, required a done pulse", bound);
    end
    repeat (3) tick();
    check("done_once", done_cnt, 32'd1);
    check("stream_complete", exp_q.size(), 32'd0);
  endtask

  task automatic wait_words(input int c, input int n);
    int k;
    for (k = 0; k < 2000 && words[c] < n; k++) tick();
    if (words[c] < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_words: got %0d words on ch %0d, required %0d", words[c], c, n);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ch_enable = '0;
    bus.out_ready = 1'b1;
    stuck = '0;
    cur_mask = '0;
    clear_stats();
    repeat (3) tick();
    check("reset_outputs", {10'b0, bus.adc_bg, bus.adc_rdreq, bus.out_valid, bus.out_data,
                            bus.out_ch, bus.busy, bus.done, bus.timeout_err}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_busy", {31'b0, bus.busy}, 32'd0);

    // Full round, all four channels
    for (int c = 0; c < 4; c++) load(c, 8);
    expect_round(4'b1111, 8, 8, 8, 8);
    start_round(4'b1111);
    check("busy_after_start", {31'b0, bus.busy}, 32'd1);
    finish_round(2000);
    check("full_bg_cycles", bg_cycles, 32'd1);
    check("full_bg_value", {28'b0, bg_val}, 32'hf);
    for (int c = 0; c < 4; c++) check("full_rdreq_count", rd_cnt[c], 32'd8);
    for (int c = 0; c < 4; c++) check("full_words", words[c], 32'd8);
    check("full_busy_low", {31'b0, bus.busy}, 32'd0);

    // Sparse mask, with starts issued mid-round that must be ignored
    for (int c = 0; c < 4; c++) load(c, 8);
    expect_round(4'b0101, 8, 8, 8, 8);
    start_round(4'b0101);
    repeat (40) tick();
    pulse_ignored_start(4'b1010);
    tick();
    pulse_ignored_start(4'b1111);
    finish_round(2000);
    check("sparse_bg_value", {28'b0, bg_val}, 32'h5);
    check("sparse_bg_cycles", bg_cycles, 32'd1);
    check("sparse_rdreq1", rd_cnt[1], 32'd0);
    check("sparse_rdreq3", rd_cnt[3], 32'd0);
    check("sparse_words0", words[0], 32'd8);
    check("sparse_words2", words[2], 32'd8);
    flush_fifos();
    repeat (2) tick();

    // Backpressure mid-channel
    load(0, 8); load(1, 8);
    expect_round(4'b0011, 8, 8, 0, 0);
    start_round(4'b0011);
    wait_words(0, 3);
    bus.out_ready = 1'b0;
    repeat (10) tick();
    bus.out_ready = 1'b1;
    finish_round(2000);
    check("bp_words0", words[0], 32'd8);
    check("bp_words1", words[1], 32'd8);

    // Timeout: channel 3 never ends
    stuck = 4'b1000;
    for (int c = 0; c < 4; c++) load(c, 8);
    start_round(4'b1111);
    finish_round(2000);
    check("to_latency", done_at - bg_at, 32'd50);
    check("to_err_at_done", {31'b0, terr_at_done}, 32'd1);
    check("to_no_reads", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], 32'd0);
    check("to_err_sticky", {31'b0, bus.timeout_err}, 32'd1);
    stuck = '0;
    flush_fifos();
    repeat (2) tick();

    // Empty mask: clears the error and finishes at once
    start_round(4'b0000);
    check("mask0_err_cleared", {31'b0, bus.timeout_err}, 32'd0);
    check("mask0_done_now", {31'b0, bus.done}, 32'd1);
    finish_round(20);
    check("mask0_no_bg", bg_cycles, 32'd0);

    // Early empty on channel 1
    load(0, 8); load(1, 3); load(2, 8); load(3, 8);
    expect_round(4'b1111, 8, 3, 8, 8);
    start_round(4'b1111);
    finish_round(2000);
    check("early_words1", words[1], 32'd3);
    check("early_words2", words[2], 32'd8);

    // Reset during channel 2 readout
    for (int c = 0; c < 4; c++) load(c, 8);
    expect_round(4'b1111, 8, 8, 8, 8);
    start_round(4'b1111);
    wait_words(2, 2);
    #2;
    rst = 1'b1;
    #1;
    check("midread_reset_outputs", {10'b0, bus.adc_bg, bus.adc_rdreq, bus.out_valid, bus.out_data,
                                    bus.out_ch, bus.busy, bus.done, bus.timeout_err}, 32'd0);
    exp_q.delete();
    flush_fifos();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", {31'b0, bus.busy}, 32'd0);
    start_round(4'b0000);
    check("post_reset_done", {31'b0, bus.done}, 32'd1);
    finish_round(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_capture_scheduler.md
Name: adc_capture_scheduler

Overview:
Sequences one capture round across the per-channel ADC capture drivers. On start it pulses each enabled channel's begin line and waits for all enabled end flags. It then drains each enabled channel's capture FIFO in ascending channel order onto a single 8-bit valid/ready stream for the host link. It sits between the host command decoder and the N per-channel ADC drivers.

Parameters:
N_CH, 4, number of ADC channels (2..8)
CH_W, 2, width of channel index; must equal clog2(N_CH)
WORDS, 4096, maximum words read per channel per round (1..8191)
TIMEOUT, 1000000, cycles allowed in WAIT_END before abort

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous reset, active-high
start  in  1  one-cycle request to begin a round
ch_enable  in  N_CH  channel mask, sampled on accepted start
adc_end  in  N_CH  per-channel capture-complete level
adc_empty  in  N_CH  per-channel FIFO empty
adc_q  in  8*N_CH  packed FIFO outputs; channel i is at bits [8i+7:8i]
adc_bg  out  N_CH  one-cycle begin pulse per enabled channel
adc_rdreq  out  N_CH  one-hot FIFO read request
out_data  out  8  stream data
out_ch  out  CH_W  channel index of out_data
out_valid  out  1  stream valid
out_ready  in  1  stream ready
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of round
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (async, any state): FSM returns to IDLE. All outputs become 0. Mask, counters and pending flag are cleared. Abandoning a round mid-operation is intended.
- FSM states: IDLE, ARM, WAIT_END, SELECT, READ, DONE.
- IDLE: start=1 latches mask<=ch_enable, clears timeout_err and sets busy. Next state is ARM, or DONE if the mask is 0. start is ignored in every state except IDLE.
- ARM: one cycle. adc_bg<=mask (registered, so the pulse lasts exactly 1 cycle). The timeout counter is cleared. Next state is WAIT_END.
- WAIT_END: leave when (adc_end & mask)==mask, going to SELECT with ch<=lowest set bit of mask.
- WAIT_END timeout: the counter increments each cycle. When it reaches TIMEOUT-1 without completion, set timeout_err=1 and go to DONE. No readout occurs on timeout.
- SELECT: if mask[ch]=0, advance ch. Otherwise clear word_cnt and go to READ. After the highest channel, go to DONE.
- READ protocol: the FIFO has 1-cycle read latency, so q is valid the cycle after rdreq. At most one read is in flight.
  - Issue condition: adc_rdreq[ch]=1 for one cycle when !pending && !out_valid && !adc_empty[ch] && word_cnt<WORDS. This sets pending=1.
  - Capture cycle: out_data<=adc_q[ch], out_ch<=ch, out_valid<=1, pending<=0, word_cnt<=word_cnt+1.
  - out_valid clears on the first cycle with out_ready=1. out_data is held stable while out_valid && !out_ready.
  - Peak throughput is one word per 3 cycles.
- Channel finish: the current channel is finished when !pending && !out_valid and (word_cnt==WORDS or adc_empty[ch]). On finish, go to SELECT with ch+1.
- DONE: one cycle. done=1, busy<=0, next state IDLE. timeout_err stays set until the next accepted start.
- Width rules:
  - word_cnt is 13 bits; it never wraps because it is capped at WORDS.
  - The timeout counter is 24 bits and saturates.
  - ch is CH_W bits; the end test uses ch==N_CH-1 rather than relying on wrap.
- Simultaneous events:
  - out_ready together with a capture in the same cycle cannot occur, because a read is only issued when out_valid=0.
  - adc_end for a masked-off channel is ignored.
  - adc_empty rising mid-channel ends that channel early, with no error.

Test Plan:
- Full round, N_CH=4, mask=4'b1111, WORDS=8: adc_end rises 20 cycles after adc_bg; FIFOs hold 8 words each (0x10+i*0x10+k); out_ready=1. Expect adc_bg=4'b1111 for exactly 1 cycle, then 32 stream words in channel order 0..3 with matching out_ch. done pulses once and busy falls the same cycle.
- Sparse mask=4'b0101: only adc_bg[0] and adc_bg[2] pulse; adc_rdreq[1] and adc_rdreq[3] are never asserted; stream carries only channels 0 and 2.
- Backpressure: out_ready low for 10 cycles mid-channel. Expect out_data/out_ch stable, no adc_rdreq, and no word lost or duplicated (word count 8 per channel).
- Timeout, TIMEOUT=50: adc_end[3] never rises. Expect timeout_err=1 at cycle 50 of WAIT_END, done pulse, no adc_rdreq. The next start clears timeout_err.
- Early empty: channel 1 FIFO holds 3 words with WORDS=8. Expect 3 words from channel 1, then readout moves to channel 2 with no stall.
- Reset mid-READ, plus ignored starts: assert Reset during channel 2 readout. All outputs go to 0 immediately and the FSM returns to IDLE. Separately, start pulses while busy have no effect; mask=0 gives done after 1 cycle with no adc_bg.
